// File: rtl/rf_port_arb_pkg.sv
// Shared types and defaults for the two-port register-file arbiter (rf_port_arb).
package rf_port_arb_pkg;

  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_t;

  function automatic req_idx_t other_req(input req_idx_t r);
    return (r == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// Two-way winner select. Round-robin on ties by default; requester 0 always
// wins ties when RF_ARB_FIXED_PRIO_EN is defined.
module rf_rr_pick
  import rf_port_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t last,
  output logic     valid,
  output req_idx_t idx
);

`ifdef RF_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    valid = req0 | req1;
    idx   = req0 ? REQ0 : REQ1;
  end
`else
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      // Tie goes to whichever requester was not served most recently.
      idx = other_req(last);
    end else if (req0) begin
      idx = REQ0;
    end else begin
      idx = REQ1;
    end
  end
`endif

endmodule

// File: rtl/rf_port_arb.sv
// Two-requester arbiter in front of a single external register file.
// Policy macro: RF_ARB_FIXED_PRIO_EN (fixed priority to requester 0 when defined).
module rf_port_arb
  import rf_port_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] rf_rAddr,
  input  logic [DW-1:0] rf_rDout,
  output logic [AW-1:0] rf_wAddr,
  output logic [DW-1:0] rf_wDin,
  output logic          rf_wEna,
  output logic          busy
);

  state_t        state_q, state_d;
  req_idx_t      win_q;
  req_idx_t      last_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          pick_valid;
  req_idx_t      pick_idx;
  logic          latch;
  logic          serve;

  rf_rr_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign serve = (state_q == SERVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The ack cycle blocks arbitration so a still-high req is not served twice.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid && !(ack0 || ack1)) begin
          state_d = SERVE;
          latch   = 1'b1;
        end
      end
      SERVE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= REQ0;
      last_q  <= REQ1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch) begin
      win_q  <= pick_idx;
      last_q <= pick_idx;
      if (pick_idx == REQ0) begin
        we_q    <= we0;
        addr_q  <= addr0;
        wdata_q <= wdata0;
      end else begin
        we_q    <= we1;
        addr_q  <= addr1;
        wdata_q <= wdata1;
      end
    end
  end

  // The falling-edge write has landed by the edge that ends SERVE, so a write
  // returns its own data here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= serve && (win_q == REQ0);
      ack1 <= serve && (win_q == REQ1);
      if (serve && (win_q == REQ0)) begin
        rdata0 <= rf_rDout;
      end
      if (serve && (win_q == REQ1)) begin
        rdata1 <= rf_rDout;
      end
    end
  end

  always_comb begin
    busy     = serve;
    rf_wEna  = serve & we_q;
    rf_rAddr = serve ? addr_q : '0;
    rf_wAddr = serve ? addr_q : '0;
    rf_wDin  = serve ? wdata_q : '0;
  end

endmodule

// File: tb/tb_rf_port_arb.sv
// Scoreboard bench for rf_port_arb with a behavioural register file
// (async read, falling-edge write, entry i preloaded with 2*i).
module tb_rf_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [5:0]  rf_rAddr, rf_wAddr;
  logic [31:0] rf_rDout, rf_wDin;
  logic        rf_wEna;
  logic        busy;

  logic [31:0] mem [0:63];
  bit          init_done;

  int cyc;
  int n_pass;
  int n_total;
  int wena_cnt;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon0, mon1;

  rf_port_arb #(.AW(6), .DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .rf_rAddr (rf_rAddr),
    .rf_rDout (rf_rDout),
    .rf_wAddr (rf_wAddr),
    .rf_wDin  (rf_wDin),
    .rf_wEna  (rf_wEna),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(2 * i);
      init_done <= 1'b1;
    end else if (rf_wEna) begin
      mem[rf_wAddr] <= rf_wDin;
    end
  end

  assign rf_rDout = mem[rf_rAddr];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  // Monitor: pops the per-port queue on every ack and checks data and cycle.
  always @(negedge clk) begin
    if (rf_wEna) wena_cnt++;
    if (ack0) begin
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack0: got ack0 at cycle %0d, expected none", cyc);
      end else begin
        mon0 = q0.pop_front();
        check("rdata0", {32'd0, rdata0}, {32'd0, mon0.data});
        check("ack0_cycle", 64'(cyc), 64'(mon0.cyc));
      end
    end
    if (ack1) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack1: got ack1 at cycle %0d, expected none", cyc);
      end else begin
        mon1 = q1.pop_front();
        check("rdata1", {32'd0, rdata1}, {32'd0, mon1.data});
        check("ack1_cycle", 64'(cyc), 64'(mon1.cyc));
      end
    end
  end

  // Issue one access from an idle, non-ack cycle; returns one cycle after ack.
  task automatic access(input int p, input logic w, input logic [5:0] a,
                        input logic [31:0] d, input logic [31:0] exp_data, input int lat);
    exp_t e;
    bit   got;
    e.data = exp_data;
    e.cyc  = cyc + lat;
    got    = 1'b0;
    if (p == 0) begin
      q0.push_back(e);
      we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      q1.push_back(e);
      we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if ((p == 0) ? ack0 : ack1) got = 1'b1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL ack%0d_timeout: got no ack, expected ack within 20 cycles", p);
    end
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   c0;
    exp_t e;
    int   lat0, lat1;

    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);

    check("rst_ack0", {63'd0, ack0}, 64'd0);
    check("rst_ack1", {63'd0, ack1}, 64'd0);
    check("rst_rdata0", {32'd0, rdata0}, 64'd0);
    check("rst_rdata1", {32'd0, rdata1}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_wena", {63'd0, rf_wEna}, 64'd0);
    check("rst_raddr", {58'd0, rf_rAddr}, 64'd0);
    check("rst_waddr", {58'd0, rf_wAddr}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read, then a write and its read-back.
    wena_cnt = 0;
    access(0, 1'b0, 6'd1, 32'd0, 32'd2, 2);
    check("read_wena_count", 64'(wena_cnt), 64'd0);
    wena_cnt = 0;
    access(1, 1'b1, 6'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2);
    check("write_wena_count", 64'(wena_cnt), 64'd1);

    // Both held: alternating under round-robin, req0 only under fixed priority.
    c0 = cyc;
    e.data = 32'd4; e.cyc = c0 + 2;  q0.push_back(e);
`ifdef RF_ARB_FIXED_PRIO_EN
    e.data = 32'd4; e.cyc = c0 + 5;  q0.push_back(e);
    e.data = 32'd4; e.cyc = c0 + 8;  q0.push_back(e);
    e.data = 32'd4; e.cyc = c0 + 11; q0.push_back(e);
`else
    e.data = 32'd6; e.cyc = c0 + 5;  q1.push_back(e);
    e.data = 32'd4; e.cyc = c0 + 8;  q0.push_back(e);
    e.data = 32'd6; e.cyc = c0 + 11; q1.push_back(e);
`endif
    we0 = 1'b0; addr0 = 6'd2; req0 = 1'b1;
    we1 = 1'b0; addr1 = 6'd3; req1 = 1'b1;
    repeat (11) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    access(0, 1'b0, 6'd5, 32'd0, 32'hDEADBEEF, 2);

    // Simultaneous one-shot pair after req0 was served last.
`ifdef RF_ARB_FIXED_PRIO_EN
    lat0 = 2; lat1 = 5;
`else
    lat0 = 5; lat1 = 2;
`endif
    fork
      access(0, 1'b0, 6'd6, 32'd0, 32'd12, lat0);
      access(1, 1'b0, 6'd4, 32'd0, 32'd8, lat1);
    join

    // Back-to-back reads from req0: one ack every 3 cycles.
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      e.data = 32'(2 * i); e.cyc = c0 + 2 + 3 * i; q0.push_back(e);
    end
    we0 = 1'b0; addr0 = 6'd0; req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        check("b2b_busy", {63'd0, busy}, (k == 1) ? 64'd1 : 64'd0);
        if (k == 2) begin
          if (i == 3) req0 = 1'b0;
          else        addr0 = 6'(i + 1);
        end
        @(negedge clk);
      end
    end

    // Reset in the middle of a write to addr 7.
    we0 = 1'b1; addr0 = 6'd7; wdata0 = 32'h12345678; req0 = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    check("abort_wena_pre", {63'd0, rf_wEna}, 64'd1);
    check("abort_waddr_pre", {58'd0, rf_wAddr}, 64'd7);
    #1 rst_n = 1'b0;
    #1;
    check("abort_wena", {63'd0, rf_wEna}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_ack0", {63'd0, ack0}, 64'd0);
    check("abort_ack1", {63'd0, ack1}, 64'd0);
    check("abort_rdata0", {32'd0, rdata0}, 64'd0);
    check("abort_rdata1", {32'd0, rdata1}, 64'd0);
    @(negedge clk);
    req0 = 1'b0; we0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 1'b0, 6'd7, 32'd0, 32'd14, 2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_port_arb.md
RF_PORT_ARB -- requirements
Module: rf_port_arb

Interface
REQ-001 The block SHALL have parameter AW, default 6, meaning register-file address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning register-file data width.
REQ-003 Port clk, input, 1: single clock; all block state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Ports req0/req1, input, 1: requester N asks for one register-file access; held high until ackN.
REQ-006 Ports we0/we1, input, 1: per-requester access type; 1 = write, 0 = read; stable while reqN is high.
REQ-007 Ports addr0/addr1, input, AW: per-requester register address; stable while reqN is high.
REQ-008 Ports wdata0/wdata1, input, DW: per-requester write data; stable while reqN is high.
REQ-009 Ports ack0/ack1, output, 1: one-cycle completion pulse to requester N.
REQ-010 Ports rdata0/rdata1, output, DW: registered result for requester N; valid from the ackN cycle until the next ackN.
REQ-011 Port rf_rAddr, output, AW: drives the register-file read address.
REQ-012 Port rf_rDout, input, DW: asynchronous read data returned by the register file.
REQ-013 Ports rf_wAddr, rf_wDin and rf_wEna, outputs, AW/DW/1: drive the register-file write port (write takes effect on the falling clk edge).
REQ-014 Port busy, output, 1: high while an access is in service.

Function
REQ-015 The FSM SHALL have two states: IDLE and SERVE.
REQ-016 In IDLE with any reqN high and no ack pulse in the current cycle, the FSM SHALL latch the winner index, we, addr and wdata, and go to SERVE on the next edge.
REQ-017 SERVE SHALL last exactly one cycle and then return to IDLE.
REQ-018 In SERVE: rf_rAddr = rf_wAddr = latched addr; rf_wDin = latched wdata; rf_wEna = latched we.
REQ-019 Outside SERVE, rf_wEna SHALL be 0; rf_rAddr and rf_wAddr SHALL be 0.
REQ-020 At the edge ending SERVE, rdataN SHALL capture rf_rDout and ackN SHALL pulse high for one cycle.
REQ-021 For a write, rdataN SHALL equal the value just written, because the falling-edge write lands before the capture edge.
REQ-022 Latency SHALL be exactly 2 cycles from reqN sampled high in IDLE to ackN high.
REQ-023 Peak throughput SHALL be one access per 3 cycles (IDLE, SERVE, ack/IDLE).
REQ-024 A req still high during its own ack cycle SHALL NOT be re-arbitrated.
REQ-025 Simultaneous req0 and req1: the winner SHALL be chosen per REQ-033/034; the loser stays pending and is served next.
REQ-026 busy SHALL be high exactly in SERVE.
REQ-027 A requester dropping reqN before its ack is a protocol violation; an access already latched SHALL still complete and ack.

Reset
REQ-028 While rst_n is low, asynchronously: FSM = IDLE, ack0 = ack1 = 0, rdata0 = rdata1 = 0, busy = 0, rf_wEna = 0.
REQ-029 On reset, the round-robin pointer SHALL favour requester 0.
REQ-030 Reset asserted during SERVE SHALL abort the access; no ack is issued, and rf_wEna drops immediately.

Configuration
REQ-031 Macro RF_ARB_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-032 The macro SHALL change only winner selection; timing is identical with and without it.
REQ-033 With RF_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties.
REQ-034 Without it, arbitration SHALL be round-robin: the requester not served last wins ties.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, AW/DW defaults and the requester-index type.
REQ-036 One sub-module, rf_rr_pick (2-way winner select, macro-aware), SHALL be used.
REQ-037 The register file SHALL remain an external instance.

Verification
REQ-038 Reset, then req0 read addr 1 -> ack0 at cycle 2; rdata0 = 2; rf_wEna never high.
REQ-039 req1 write addr 5 data 0xDEADBEEF -> rf_wEna high one cycle; ack1 pulses; rdata1 = 0xDEADBEEF; a later read of addr 5 returns 0xDEADBEEF.
REQ-040 req0 and req1 both high in the same cycle, held: round-robin order is ack0 then ack1 three cycles later; with RF_ARB_FIXED_PRIO_EN, repeated req0 starves req1.
REQ-041 rst_n pulled low mid-SERVE of a write to addr 7 -> no ack; rf_wEna low immediately; busy = 0; rdata0 = rdata1 = 0.
REQ-042 Back-to-back reads from req0, addr 0..3 -> one ack every 3 cycles; busy pattern 0,1,0 repeating.
